// File: rtl/maindec_mc_if.sv
// Control bus between the multi-cycle main decoder and the datapath.
// The decoder drives enables, mux selects and debug state; the datapath returns the opcode fields and memory readiness.
interface maindec_mc_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic       pcwrite;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       branch;
  logic       branch_ne;
  logic       iord;
  logic       zeroext;
  logic [1:0] memtoreg;
  logic [1:0] regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] aluop;
  logic       exc;
  logic [4:0] state;

  modport master (
    input  op, funct, mem_ready,
    output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, branch_ne,
           iord, zeroext, memtoreg, regdst, alusrcb, pcsrc, aluop, exc, state
  );

  modport slave (
    output op, funct, mem_ready,
    input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, branch_ne,
           iord, zeroext, memtoreg, regdst, alusrcb, pcsrc, aluop, exc, state
  );
endinterface

// File: rtl/maindec_mc.sv
// Main control FSM for the multi-cycle MIPS core: Moore outputs registered from the next state,
// with write strobes gated by memory readiness and reset.
module maindec_mc #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_ISA       = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  maindec_mc_if.master  bus
);

  typedef enum logic [4:0] {
    FETCH   = 5'd0,
    DECODE  = 5'd1,
    MEMADR  = 5'd2,
    MEMRD   = 5'd3,
    MEMWB   = 5'd4,
    MEMWR   = 5'd5,
    RTYPEEX = 5'd6,
    RTYPEWB = 5'd7,
    BEQEX   = 5'd8,
    ADDIEX  = 5'd9,
    IMMWB   = 5'd10,
    JEX     = 5'd11,
    BNEEX   = 5'd12,
    IMMEX   = 5'd13,
    JALEX   = 5'd14,
    JREX    = 5'd15,
    EXC     = 5'd16
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       zeroext;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       exc;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  function automatic state_t decode_op(input logic [5:0] op, input logic [5:0] funct);
    state_t ns;
    case (op)
      OP_LW, OP_SW:              ns = MEMADR;
      OP_RTYPE:                  ns = (EXT_ISA && funct == FN_JR) ? JREX : RTYPEEX;
      OP_BEQ:                    ns = BEQEX;
      OP_ADDI:                   ns = ADDIEX;
      OP_J:                      ns = JEX;
      OP_BNE:                    ns = EXT_ISA ? BNEEX : EXC;
      OP_ANDI, OP_ORI, OP_SLTI:  ns = EXT_ISA ? IMMEX : EXC;
      OP_JAL:                    ns = EXT_ISA ? JALEX : EXC;
      default:                   ns = EXC;
    endcase
    return ns;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] funct, input logic rdy);
    state_t ns;
    case (s)
      FETCH:   ns = rdy ? DECODE : FETCH;
      DECODE:  ns = decode_op(op, funct);
      MEMADR:  ns = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   ns = rdy ? MEMWB : MEMRD;
      MEMWR:   ns = rdy ? FETCH : MEMWR;
      RTYPEEX: ns = RTYPEWB;
      ADDIEX:  ns = IMMWB;
      IMMEX:   ns = IMMWB;
      EXC:     ns = EXC;
      default: ns = FETCH;
    endcase
    return ns;
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req = 1'b1; c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 2'b01; end
      MEMWR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 3'b010; end
      RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 2'b01; end
      BEQEX: begin
        c.alusrca = 1'b1; c.branch = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01;
      end
      BNEEX: begin
        c.alusrca = 1'b1; c.branch_ne = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01;
      end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      IMMEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
        // Logical immediates zero-extend; SLTI keeps sign-extension.
        case (op)
          OP_ANDI: begin c.aluop = 3'b011; c.zeroext = 1'b1; end
          OP_ORI:  begin c.aluop = 3'b100; c.zeroext = 1'b1; end
          default: c.aluop = 3'b101;
        endcase
      end
      IMMWB:   c.regwrite = 1'b1;
      JEX:     begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
      JALEX: begin
        c.pcwrite = 1'b1; c.pcsrc = 2'b10; c.regwrite = 1'b1;
        c.regdst = 2'b10; c.memtoreg = 2'b10;
      end
      JREX:    begin c.pcwrite = 1'b1; c.pcsrc = 2'b11; end
      EXC:     c.exc = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  logic   rdy;
  state_t state_q;
  ctrl_t  ctrl_q;

  assign rdy = bus.mem_ready | ~MEM_HANDSHAKE;

  // State and control word are registered together so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH, bus.op);
    end else begin
      state_q <= next_state(state_q, bus.op, bus.funct, rdy);
      ctrl_q  <= ctrl_of(next_state(state_q, bus.op, bus.funct, rdy), bus.op);
    end
  end

  // Strobes drop the instant reset goes low; FETCH writes only land on the ready cycle.
  assign bus.pcwrite   = reset & ctrl_q.pcwrite & (rdy | (state_q != FETCH));
  assign bus.irwrite   = reset & ctrl_q.irwrite & rdy;
  assign bus.memwrite  = reset & ctrl_q.memwrite;
  assign bus.regwrite  = reset & ctrl_q.regwrite;
  assign bus.branch    = reset & ctrl_q.branch;
  assign bus.branch_ne = reset & ctrl_q.branch_ne;

  assign bus.mem_req   = ctrl_q.mem_req;
  assign bus.alusrca   = ctrl_q.alusrca;
  assign bus.iord      = ctrl_q.iord;
  assign bus.zeroext   = ctrl_q.zeroext;
  assign bus.memtoreg  = ctrl_q.memtoreg;
  assign bus.regdst    = ctrl_q.regdst;
  assign bus.alusrcb   = ctrl_q.alusrcb;
  assign bus.pcsrc     = ctrl_q.pcsrc;
  assign bus.aluop     = ctrl_q.aluop;
  assign bus.exc       = ctrl_q.exc;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_maindec_mc.sv
// Random-instruction bench for maindec_mc in three parameter builds, each tracked by
// an instruction-level model (state sequence per opcode plus per-state output table).
module tb_maindec_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_v [3];
  logic       rdy_v   [3];
  logic [5:0] op_v    [3];
  logic [5:0] funct_v [3];

  maindec_mc_if if0 ();
  maindec_mc_if if1 ();
  maindec_mc_if if2 ();

  assign if0.op = op_v[0]; assign if0.funct = funct_v[0]; assign if0.mem_ready = rdy_v[0];
  assign if1.op = op_v[1]; assign if1.funct = funct_v[1]; assign if1.mem_ready = rdy_v[1];
  assign if2.op = op_v[2]; assign if2.funct = funct_v[2]; assign if2.mem_ready = rdy_v[2];

  maindec_mc #(.MEM_HANDSHAKE(1'b1), .EXT_ISA(1'b1)) u0 (.clk(clk), .reset(reset_v[0]), .bus(if0.master));
  maindec_mc #(.MEM_HANDSHAKE(1'b1), .EXT_ISA(1'b0)) u1 (.clk(clk), .reset(reset_v[1]), .bus(if1.master));
  maindec_mc #(.MEM_HANDSHAKE(1'b0), .EXT_ISA(1'b1)) u2 (.clk(clk), .reset(reset_v[2]), .bus(if2.master));

  logic [21:0] obs_w [3];
  logic [4:0]  obs_st[3];
  assign obs_w[0] = {if0.mem_req, if0.pcwrite, if0.memwrite, if0.irwrite, if0.regwrite, if0.alusrca, if0.branch, if0.branch_ne, if0.iord, if0.zeroext, if0.memtoreg, if0.regdst, if0.alusrcb, if0.pcsrc, if0.aluop, if0.exc};
  assign obs_w[1] = {if1.mem_req, if1.pcwrite, if1.memwrite, if1.irwrite, if1.regwrite, if1.alusrca, if1.branch, if1.branch_ne, if1.iord, if1.zeroext, if1.memtoreg, if1.regdst, if1.alusrcb, if1.pcsrc, if1.aluop, if1.exc};
  assign obs_w[2] = {if2.mem_req, if2.pcwrite, if2.memwrite, if2.irwrite, if2.regwrite, if2.alusrca, if2.branch, if2.branch_ne, if2.iord, if2.zeroext, if2.memtoreg, if2.regdst, if2.alusrcb, if2.pcsrc, if2.aluop, if2.exc};
  assign obs_st[0] = if0.state;
  assign obs_st[1] = if1.state;
  assign obs_st[2] = if2.state;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: each instruction is the list of states it walks through.
  int hs  [3] = '{1, 1, 0};
  int ext [3] = '{1, 0, 1};
  int plan[3][6];
  int plen[3];
  int pos [3];
  int exccnt[3];
  int seen[17];

  logic [5:0] optab[14] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                            6'b000010, 6'b000101, 6'b001100, 6'b001101, 6'b001010,
                            6'b000011, 6'b111111, 6'b011000, 6'b000000};

  function automatic void build(input int k);
    logic [5:0] op;
    logic       x;
    op = op_v[k];
    x  = (ext[k] != 0);
    plan[k] = '{0, 1, 16, 0, 0, 0}; plen[k] = 3;
    case (op)
      6'b100011: begin plan[k] = '{0, 1, 2, 3, 4, 0}; plen[k] = 5; end
      6'b101011: begin plan[k] = '{0, 1, 2, 5, 0, 0}; plen[k] = 4; end
      6'b000000: begin
        if (x && funct_v[k] == 6'b001000) begin plan[k] = '{0, 1, 15, 0, 0, 0}; plen[k] = 3; end
        else begin plan[k] = '{0, 1, 6, 7, 0, 0}; plen[k] = 4; end
      end
      6'b000100: begin plan[k] = '{0, 1, 8, 0, 0, 0}; plen[k] = 3; end
      6'b001000: begin plan[k] = '{0, 1, 9, 10, 0, 0}; plen[k] = 4; end
      6'b000010: begin plan[k] = '{0, 1, 11, 0, 0, 0}; plen[k] = 3; end
      6'b000101: if (x) begin plan[k] = '{0, 1, 12, 0, 0, 0}; plen[k] = 3; end
      6'b001100, 6'b001101, 6'b001010:
                 if (x) begin plan[k] = '{0, 1, 13, 10, 0, 0}; plen[k] = 4; end
      6'b000011: if (x) begin plan[k] = '{0, 1, 14, 0, 0, 0}; plen[k] = 3; end
      default: ;
    endcase
  endfunction

  function automatic void pick(input int k);
    op_v[k]    = optab[$urandom_range(0, 13)];
    funct_v[k] = ($urandom_range(0, 1) == 1) ? 6'b001000 : 6'($urandom);
    build(k);
    pos[k] = 0;
  endfunction

  function automatic logic [21:0] exp_outs(input int s, input logic [5:0] op,
                                           input logic r, input logic rst_n);
    logic mr, pw, mw, iw, rw, asa, br, bne, io, ze, ex;
    logic [1:0] m2r, rd, asb, ps;
    logic [2:0] ao;
    {mr, pw, mw, iw, rw, asa, br, bne, io, ze, ex} = '0;
    {m2r, rd, asb, ps} = '0;
    ao = 3'b000;
    case (s)
      0:  begin mr = 1; asb = 2'b01; iw = r; pw = r; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mr = 1; io = 1; mw = 1; end
      6:  begin asa = 1; ao = 3'b010; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; br = 1; ao = 3'b001; ps = 2'b01; end
      12: begin asa = 1; bne = 1; ao = 3'b001; ps = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      13: begin
        asa = 1; asb = 2'b10;
        if (op == 6'b001100) begin ao = 3'b011; ze = 1; end
        else if (op == 6'b001101) begin ao = 3'b100; ze = 1; end
        else ao = 3'b101;
      end
      10: rw = 1;
      11: begin pw = 1; ps = 2'b10; end
      14: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      15: begin pw = 1; ps = 2'b11; end
      16: ex = 1;
      default: ;
    endcase
    if (!rst_n) begin pw = 0; iw = 0; mw = 0; rw = 0; br = 0; bne = 0; end
    return {mr, pw, mw, iw, rw, asa, br, bne, io, ze, m2r, rd, asb, ps, ao, ex};
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset_v[k] = 1'b0;
      rdy_v[k]   = 1'b1;
      exccnt[k]  = 0;
      pick(k);
    end
    for (int i = 0; i < 17; i++) seen[i] = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic r;
        r = rdy_v[k] | (hs[k] == 0);
        check($sformatf("u%0d_state", k), {27'b0, obs_st[k]}, plan[k][pos[k]]);
        check($sformatf("u%0d_outs_st%0d", k, plan[k][pos[k]]), {10'b0, obs_w[k]},
              {10'b0, exp_outs(plan[k][pos[k]], op_v[k], r, reset_v[k])});
        seen[plan[k][pos[k]]]++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        int  s;
        logic r;
        s = plan[k][pos[k]];
        r = rdy_v[k] | (hs[k] == 0);
        if (!reset_v[k]) begin
          exccnt[k] = 0;
          build(k);
          pos[k] = 0;
        end else if (s == 16) begin
          exccnt[k]++;
        end else if ((s == 0 || s == 3 || s == 5) && !r) begin
          pos[k] = pos[k];
        end else begin
          pos[k]++;
          if (pos[k] == plen[k]) pick(k);
        end
        rdy_v[k]   = ($urandom_range(0, 2) != 0);
        reset_v[k] = !(cyc < 1 || exccnt[k] >= 10 || $urandom_range(0, 59) == 0);
      end
    end

    // Every encoded state should have been visited at least once across the builds.
    for (int i = 0; i < 17; i++)
      check($sformatf("visited_st%0d", i), {31'b0, (seen[i] > 0)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
